// File: rtl/stage_skid_reg.sv
// stage_skid_reg: two-entry pipeline stage register (main + skid) with
// fully registered ready, flush kill and a saturating back-pressure counter.
module stage_skid_reg #(
  parameter int PC_W      = 64,
  parameter int PAYLOAD_W = 128,
  parameter int STALL_W   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [STALL_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  logic [PC_W-1:0]      main_pc_p0;
  logic [PAYLOAD_W-1:0] main_payload_p0;
  logic [PC_W-1:0]      skid_pc_p0;
  logic [PAYLOAD_W-1:0] skid_payload_p0;
  logic                 accept;
  logic                 fire;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (v == {STALL_W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  // Handshake signals come only from registered state, so ready/valid never
  // depend combinationally on the neighbouring stages.
  assign in_ready    = (state != FULL);
  assign out_valid   = (state != EMPTY);
  assign occupancy   = 2'(state);
  assign out_pc      = main_pc_p0;
  assign out_payload = main_payload_p0;
  assign accept      = in_valid & in_ready;
  assign fire        = out_valid & out_ready;

  // State machine, entry registers and stall counter; reset beats flush,
  // flush beats every handshake and leaves the data registers untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= EMPTY;
      main_pc_p0      <= '0;
      main_payload_p0 <= '0;
      skid_pc_p0      <= '0;
      skid_payload_p0 <= '0;
      stall_cnt       <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush) begin
        state <= EMPTY;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              main_pc_p0      <= in_pc;
              main_payload_p0 <= in_payload;
              state           <= BUSY;
            end
          end
          BUSY: begin
            if (fire && accept) begin
              main_pc_p0      <= in_pc;
              main_payload_p0 <= in_payload;
            end else if (fire) begin
              state <= EMPTY;
            end else if (accept) begin
              skid_pc_p0      <= in_pc;
              skid_payload_p0 <= in_payload;
              state           <= FULL;
            end
          end
          FULL: begin
            if (fire) begin
              main_pc_p0      <= skid_pc_p0;
              main_payload_p0 <= skid_payload_p0;
              state           <= BUSY;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_skid_reg.sv
// tb_stage_skid_reg: directed table, hand-written corner sequences and
// random traffic checked against a queue-based model of the stage.
module tb_stage_skid_reg;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [63:0]  in_pc;
  logic [127:0] in_payload;

  logic         in_ready, out_valid;
  logic [63:0]  out_pc;
  logic [127:0] out_payload;
  logic [1:0]   occupancy;
  logic [31:0]  stall_cnt;

  logic         in_ready1, out_valid1;
  logic [63:0]  out_pc1;
  logic [127:0] out_payload1;
  logic [1:0]   occupancy1;
  logic [3:0]   stall_cnt1;

  always #5 clock = ~clock;

  stage_skid_reg dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_payload(out_payload),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  stage_skid_reg #(.STALL_W(4)) dut4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1), .out_payload(out_payload1),
    .occupancy(occupancy1), .stall_cnt(stall_cnt1)
  );

  typedef struct packed {
    logic [63:0]  pc;
    logic [127:0] pl;
  } ent_t;

  // Reference model: an ordered queue of held entries, the last head shown
  // downstream, and the two back-pressure counters.
  ent_t        q[$];
  ent_t        emerged[$];
  ent_t        head;
  logic [31:0] m_stall;
  logic [3:0]  m_stall4;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkpl(input logic [63:0] pc);
    return {~pc, pc};
  endfunction

  task automatic compare_model();
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("out_pc", 128'(out_pc), 128'(head.pc));
    chk("out_payload", out_payload, head.pl);
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    chk("stall_cnt4", 128'(stall_cnt1), 128'(m_stall4));
    chk("out_pc4", 128'(out_pc1), 128'(head.pc));
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, then compare both instances shortly after.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [63:0] pc, input logic [127:0] pl, input logic ordy);
    bit m_ready, m_valid, acc, fr;
    @(negedge clock);
    reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_payload = pl; out_ready = ordy;
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);
    acc = iv && m_ready;
    fr  = m_valid && ordy;
    @(posedge clock);
    if (rst) begin
      q.delete();
      head = '0;
      m_stall = '0;
      m_stall4 = '0;
    end else begin
      if (m_valid && !ordy) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 1;
      end
      if (fl) begin
        q.delete();
      end else begin
        if (fr) emerged.push_back(q.pop_front());
        if (acc) q.push_back('{pc: pc, pl: pl});
        if (q.size() > 0) head = q[0];
      end
    end
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        rst, fl, iv;
    logic [63:0] pc;
    logic        ordy;
    logic        e_valid;
    logic [1:0]  e_occ;
    logic        e_ready;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] s0;
    ent_t a, b, c;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_payload = '0;
    head = '0; m_stall = '0; m_stall4 = '0;

    // Directed table: reset, single-entry latency, then flush+input from EMPTY.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 2'd0, 1'b1, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h80000000, 1'b1, 1'b1, 2'd1, 1'b1, 64'h80000000};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0, 2'd0, 1'b1, 64'h80000000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 64'h1234,     1'b0, 1'b0, 2'd0, 1'b1, 64'h80000000};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 2'd0, 1'b1, 64'h80000000};
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, mkpl(vecs[i].pc), vecs[i].ordy);
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(vecs[i].e_valid));
      chk($sformatf("vec%0d_occ", i), 128'(occupancy), 128'(vecs[i].e_occ));
      chk($sformatf("vec%0d_ready", i), 128'(in_ready), 128'(vecs[i].e_ready));
      chk($sformatf("vec%0d_pc", i), 128'(out_pc), 128'(vecs[i].e_pc));
    end
    chk("flush_discard_none_out", 128'(emerged.size()), 128'(1));

    // Back-to-back stream of 16 PCs with downstream always ready.
    emerged.delete();
    for (int i = 0; i < 16; i++) begin
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      step(1'b0, 1'b0, 1'b1, 64'(i * 4), mkpl(64'(i * 4)), 1'b1);
      chk("stream_out_valid", 128'(out_valid), 128'(1));
      chk("stream_out_pc", 128'(out_pc), 128'(i * 4));
    end
    step(1'b0, 1'b0, 1'b0, 64'h0, '0, 1'b1);
    chk("stream_count", 128'(emerged.size()), 128'(16));
    for (int i = 0; i < 16 && i < emerged.size(); i++)
      chk("stream_order", 128'(emerged[i].pc), 128'(i * 4));

    // Skid fill: A held, B into skid, C waits upstream, then drain in order.
    emerged.delete();
    a = '{pc: 64'hA0, pl: mkpl(64'hA0)};
    b = '{pc: 64'hB0, pl: mkpl(64'hB0)};
    c = '{pc: 64'hC0, pl: mkpl(64'hC0)};
    step(1'b0, 1'b0, 1'b1, a.pc, a.pl, 1'b0);
    step(1'b0, 1'b0, 1'b1, b.pc, b.pl, 1'b0);
    chk("skid_occ_full", 128'(occupancy), 128'(2));
    chk("skid_in_ready_low", 128'(in_ready), 128'(0));
    step(1'b0, 1'b0, 1'b1, c.pc, c.pl, 1'b0);
    chk("skid_c_held", 128'(occupancy), 128'(2));
    chk("skid_head_a", 128'(out_pc), 128'(64'hA0));
    for (int i = 0; i < 6 && q.size() + emerged.size() < 3 || (i < 6 && q.size() > 0); i++) begin
      if (emerged.size() + q.size() < 3) step(1'b0, 1'b0, 1'b1, c.pc, c.pl, 1'b1);
      else step(1'b0, 1'b0, 1'b0, 64'h0, '0, 1'b1);
    end
    chk("skid_drain_count", 128'(emerged.size()), 128'(3));
    if (emerged.size() == 3) begin
      chk("skid_order_a", emerged[0], a);
      chk("skid_order_b", emerged[1], b);
      chk("skid_order_c", emerged[2], c);
    end

    // Stall counting while FULL, then flush with downstream ready.
    step(1'b0, 1'b0, 1'b1, 64'h100, mkpl(64'h100), 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h104, mkpl(64'h104), 1'b0);
    chk("stall_full", 128'(occupancy), 128'(2));
    s0 = stall_cnt;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 64'h0, '0, 1'b0);
    chk("stall_plus5", 128'(stall_cnt), 128'(s0 + 32'd5));
    step(1'b0, 1'b1, 1'b0, 64'h0, '0, 1'b1);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    chk("flush_stall_kept", 128'(stall_cnt), 128'(s0 + 32'd5));

    // Saturation on the 4-bit counter, then reset while FULL.
    step(1'b1, 1'b0, 1'b0, 64'h0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h200, mkpl(64'h200), 1'b0);
    step(1'b0, 1'b0, 1'b1, 64'h204, mkpl(64'h204), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 64'h0, '0, 1'b0);
    chk("sat_stall4", 128'(stall_cnt1), 128'(4'hF));
    chk("sat_full", 128'(occupancy1), 128'(2));
    emerged.delete();
    step(1'b1, 1'b0, 1'b1, 64'h300, mkpl(64'h300), 1'b1);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    chk("rst_pc", 128'(out_pc), 128'(0));
    chk("rst_payload", out_payload, 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    chk("rst_stall4", 128'(stall_cnt1), 128'(0));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0, '0, 1'b1);
      chk("rst_nothing_emerges", 128'(out_valid), 128'(0));
    end

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      rpc = {$urandom, $urandom};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)), rpc, {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_skid_reg.md
STAGE_SKID_REG -- requirements
Module: stage_skid_reg

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning:
- PC_W, 64, program-counter field width.
- PAYLOAD_W, 128, opaque stage payload width (regfile and memory control fields packed by the instantiating stage).
- STALL_W, 32, stall-counter width.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clock, in, 1, rising-edge clock.
- reset, in, 1, reset, synchronous, active-high.
- flush, in, 1, discard all held entries (branch/exception kill).
- in_valid, in, 1, upstream entry present.
- in_ready, out, 1, stage can accept an entry this cycle.
- in_pc, in, PC_W, upstream PC.
- in_payload, in, PAYLOAD_W, upstream payload.
- out_valid, out, 1, entry presented downstream.
- out_ready, in, 1, downstream accepts this cycle.
- out_pc, out, PC_W, head PC.
- out_payload, out, PAYLOAD_W, head payload.
- occupancy, out, 2, entries held (0..2).
- stall_cnt, out, STALL_W, count of back-pressured cycles.

Function
REQ-003 SHALL hold at most two entries: a main register (head) and a skid register, each holding pc and payload.
REQ-004 SHALL implement states EMPTY (occupancy 0), BUSY (1), FULL (2); occupancy SHALL equal the state encoding.
REQ-005 in_ready SHALL be 1 when state is not FULL, derived only from registered state, with no combinational path from out_ready or in_valid.
REQ-006 out_valid SHALL be 1 when state is not EMPTY; out_pc and out_payload SHALL be driven directly from the main register.
REQ-007 Definitions: accept = in_valid & in_ready; fire = out_valid & out_ready.
REQ-008 EMPTY: on accept, the main register SHALL load the input and the state SHALL go to BUSY; otherwise the state SHALL hold.
REQ-009 BUSY transitions:
- fire & accept: main loads the input, state stays BUSY.
- fire only: state goes to EMPTY.
- accept only: skid loads the input, state goes to FULL.
- neither: state holds.
REQ-010 FULL: on fire, the main register SHALL load the skid contents and the state SHALL go to BUSY; otherwise the state SHALL hold. No input is accepted in FULL.
REQ-011 Latency SHALL be one cycle: an entry accepted at edge N appears on out_* after edge N when the stage is empty.
REQ-012 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-013 With out_ready held at 1, the stage SHALL sustain one transfer per cycle.
REQ-014 flush SHALL force the state to EMPTY at the next edge, overriding any accept or fire in that cycle. An input offered during flush SHALL be discarded. Data registers SHALL be left unchanged.
REQ-015 Registers not loaded in a cycle SHALL retain their value; after the stage empties, out_pc and out_payload SHALL keep the last head value.
REQ-016 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, SHALL saturate at all-ones, and SHALL NOT be cleared by flush.

Reset
REQ-017 reset SHALL take priority over flush and all handshakes.
REQ-018 On reset, the block SHALL set: state EMPTY, out_valid 0, occupancy 0, out_pc 0, out_payload 0, skid register 0, stall_cnt 0. in_ready SHALL read 1 from the first cycle after reset.
REQ-019 A reset asserted while FULL SHALL discard both entries; no entry SHALL emerge after reset deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then in_valid=1, in_pc=0x80000000, out_ready=1 for one cycle -> next cycle out_valid=1, out_pc=0x80000000, occupancy=1; the cycle after, out_valid=0.
- Stream PCs 0x0,0x4,...,0x3C with out_ready=1 -> 16 outputs in consecutive cycles, in order, in_ready constantly 1.
- Load A; out_ready=0; offer B then C -> B accepted, occupancy=2, in_ready=0, C held upstream; raise out_ready -> A, B, C emerge in order, none lost.
- FULL with out_ready=0 for 5 cycles -> stall_cnt increases by 5; assert flush -> next cycle out_valid=0, occupancy=0, in_ready=1, stall_cnt unchanged.
- flush and in_valid=1 in the same cycle from EMPTY -> next cycle out_valid=0, input discarded.
- STALL_W=4 with out_ready=0 for 20 cycles -> stall_cnt=0xF; reset while FULL -> all outputs at their REQ-018 values, nothing emerges afterward.
